// File: rtl/rgb2yuv_pkg.sv
// ============================================================================
// Module : rgb2yuv_pkg
// Brief  : Shared types, widths and BT.601 coefficients for the RGB->YUV block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package rgb2yuv_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int CALC_W = 18;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    RD_R0 = 4'd1,
    RD_G0 = 4'd2,
    RD_B0 = 4'd3,
    RD_R1 = 4'd4,
    RD_G1 = 4'd5,
    RD_B1 = 4'd6,
    CALC  = 4'd7,
    WR_Y0 = 4'd8,
    WR_Y1 = 4'd9,
    WR_U  = 4'd10,
    WR_V  = 4'd11,
    DONE  = 4'd12
  } state_t;

  localparam logic signed [CALC_W-1:0] C_Y_R    =  18'sd66;
  localparam logic signed [CALC_W-1:0] C_Y_G    =  18'sd129;
  localparam logic signed [CALC_W-1:0] C_Y_B    =  18'sd25;
  localparam logic signed [CALC_W-1:0] C_U_R    = -18'sd38;
  localparam logic signed [CALC_W-1:0] C_U_G    = -18'sd74;
  localparam logic signed [CALC_W-1:0] C_U_B    =  18'sd112;
  localparam logic signed [CALC_W-1:0] C_V_R    =  18'sd112;
  localparam logic signed [CALC_W-1:0] C_V_G    = -18'sd94;
  localparam logic signed [CALC_W-1:0] C_V_B    = -18'sd18;
  localparam logic signed [CALC_W-1:0] C_Y_OFF  =  18'sd16;
  localparam logic signed [CALC_W-1:0] C_UV_OFF =  18'sd128;
  localparam logic signed [CALC_W-1:0] C_RND    =  18'sd128;

  // Rounded-up mean of two samples, used for the chroma subsampling.
  function automatic logic [DATA_W-1:0] avg2(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(1);
    return s[DATA_W:1];
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_to_yuv_converter_if.sv
// ============================================================================
// Module : rgb_to_yuv_converter_if
// Brief  : Control and memory bus of the converter; abort exists only with
//          RGB2YUV_ABORT_EN defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface rgb_to_yuv_converter_if;
  import rgb2yuv_pkg::*;

  logic              start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              done;
`ifdef RGB2YUV_ABORT_EN
  logic              abort;

  modport master (input start, input abort, input rd_data,
                  output rd_en, output rd_addr, output wr_en,
                  output wr_addr, output wr_data, output done);
  modport slave  (output start, output abort, output rd_data,
                  input rd_en, input rd_addr, input wr_en,
                  input wr_addr, input wr_data, input done);
`else
  modport master (input start, input rd_data,
                  output rd_en, output rd_addr, output wr_en,
                  output wr_addr, output wr_data, output done);
  modport slave  (output start, output rd_data,
                  input rd_en, input rd_addr, input wr_en,
                  input wr_addr, input wr_data, input done);
`endif

endinterface

`default_nettype wire

// File: rtl/rgb2yuv_calc.sv
// ============================================================================
// Module : rgb2yuv_calc
// Brief  : Combinational RGB pair -> Y0/Y1 plus shared, averaged U/V.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb2yuv_calc
  import rgb2yuv_pkg::*;
(
  input  logic [DATA_W-1:0] i_r0,
  input  logic [DATA_W-1:0] i_g0,
  input  logic [DATA_W-1:0] i_b0,
  input  logic [DATA_W-1:0] i_r1,
  input  logic [DATA_W-1:0] i_g1,
  input  logic [DATA_W-1:0] i_b1,
  output logic [DATA_W-1:0] o_y0,
  output logic [DATA_W-1:0] o_y1,
  output logic [DATA_W-1:0] o_u,
  output logic [DATA_W-1:0] o_v
);

  function automatic logic signed [CALC_W-1:0] ext(input logic [DATA_W-1:0] x);
    return $signed({{(CALC_W-DATA_W){1'b0}}, x});
  endfunction

  // Arithmetic shift floors negative chroma sums before the offset is added.
  function automatic logic [DATA_W-1:0] mac(
      input logic [DATA_W-1:0]        r,
      input logic [DATA_W-1:0]        g,
      input logic [DATA_W-1:0]        b,
      input logic signed [CALC_W-1:0] kr,
      input logic signed [CALC_W-1:0] kg,
      input logic signed [CALC_W-1:0] kb,
      input logic signed [CALC_W-1:0] off);
    logic signed [CALC_W-1:0] acc;
    acc = kr * ext(r) + kg * ext(g) + kb * ext(b) + C_RND;
    acc = (acc >>> 8) + off;
    return acc[DATA_W-1:0];
  endfunction

  logic [DATA_W-1:0] w_ra;
  logic [DATA_W-1:0] w_ga;
  logic [DATA_W-1:0] w_ba;

  assign w_ra = avg2(i_r0, i_r1);
  assign w_ga = avg2(i_g0, i_g1);
  assign w_ba = avg2(i_b0, i_b1);

  assign o_y0 = mac(i_r0, i_g0, i_b0, C_Y_R, C_Y_G, C_Y_B, C_Y_OFF);
  assign o_y1 = mac(i_r1, i_g1, i_b1, C_Y_R, C_Y_G, C_Y_B, C_Y_OFF);
  assign o_u  = mac(w_ra, w_ga, w_ba, C_U_R, C_U_G, C_U_B, C_UV_OFF);
  assign o_v  = mac(w_ra, w_ga, w_ba, C_V_R, C_V_G, C_V_B, C_UV_OFF);

endmodule

`default_nettype wire

// File: rtl/rgb_to_yuv_converter.sv
// ============================================================================
// Module : rgb_to_yuv_converter
// Brief  : Reads interleaved RGB pixel pairs, writes planar Y/U/V (4:2:2).
//          Optional abort input enabled by RGB2YUV_ABORT_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rgb_to_yuv_converter
  import rgb2yuv_pkg::*;
#(
  parameter int                NUM_PIXELS = 16,
  parameter logic [ADDR_W-1:0] RGB_BASE   = 16'h0000,
  parameter logic [ADDR_W-1:0] Y_BASE     = 16'h4000,
  parameter logic [ADDR_W-1:0] U_BASE     = 16'h8000,
  parameter logic [ADDR_W-1:0] V_BASE     = 16'hC000
) (
  input  logic                   clk,
  input  logic                   rst,
  rgb_to_yuv_converter_if.master io_bus
);

  localparam int                NUM_PAIRS = NUM_PIXELS / 2;
  localparam logic [ADDR_W-2:0] C_LAST    =
      (NUM_PAIRS > 0) ? (ADDR_W-1)'(NUM_PAIRS - 1) : '0;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-2:0] r_pair;
  logic [DATA_W-1:0] r_r0, r_g0, r_b0, r_r1, r_g1;
  logic [DATA_W-1:0] r_y0, r_y1, r_u, r_v;
  logic [DATA_W-1:0] w_y0, w_y1, w_u, w_v;
  logic [ADDR_W-1:0] w_pix0;
  logic [ADDR_W-1:0] w_rgb0;
  logic [ADDR_W-1:0] w_rgb1;
  logic              w_abort;

`ifdef RGB2YUV_ABORT_EN
  assign w_abort = io_bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_pix0 = {r_pair, 1'b0};
  assign w_rgb0 = RGB_BASE + (w_pix0 * ADDR_W'(3));
  assign w_rgb1 = w_rgb0 + ADDR_W'(3);

  // B1 is taken straight off the read bus so results register in CALC.
  rgb2yuv_calc u_calc (
    .i_r0 (r_r0),
    .i_g0 (r_g0),
    .i_b0 (r_b0),
    .i_r1 (r_r1),
    .i_g1 (r_g1),
    .i_b1 (io_bus.rd_data),
    .o_y0 (w_y0),
    .o_y1 (w_y1),
    .o_u  (w_u),
    .o_v  (w_v)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_pair  <= '0;
      r_r0    <= '0;
      r_g0    <= '0;
      r_b0    <= '0;
      r_r1    <= '0;
      r_g1    <= '0;
      r_y0    <= '0;
      r_y1    <= '0;
      r_u     <= '0;
      r_v     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE:  r_pair <= '0;
        RD_G0: r_r0   <= io_bus.rd_data;
        RD_B0: r_g0   <= io_bus.rd_data;
        RD_R1: r_b0   <= io_bus.rd_data;
        RD_G1: r_r1   <= io_bus.rd_data;
        RD_B1: r_g1   <= io_bus.rd_data;
        CALC: begin
          r_y0 <= w_y0;
          r_y1 <= w_y1;
          r_u  <= w_u;
          r_v  <= w_v;
        end
        WR_V: if (r_pair != C_LAST) r_pair <= r_pair + (ADDR_W-1)'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (io_bus.start) w_next = (NUM_PAIRS == 0) ? DONE : RD_R0;
      RD_R0:   w_next = RD_G0;
      RD_G0:   w_next = RD_B0;
      RD_B0:   w_next = RD_R1;
      RD_R1:   w_next = RD_G1;
      RD_G1:   w_next = RD_B1;
      RD_B1:   w_next = CALC;
      CALC:    w_next = WR_Y0;
      WR_Y0:   w_next = WR_Y1;
      WR_Y1:   w_next = WR_U;
      WR_U:    w_next = WR_V;
      WR_V:    w_next = (r_pair == C_LAST) ? DONE : RD_R0;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_abort && (r_state != IDLE)) w_next = IDLE;
  end

  always_comb begin
    io_bus.rd_en   = 1'b0;
    io_bus.rd_addr = '0;
    io_bus.wr_en   = 1'b0;
    io_bus.wr_addr = '0;
    io_bus.wr_data = '0;
    io_bus.done    = 1'b0;
    case (r_state)
      RD_R0: begin io_bus.rd_en = 1'b1; io_bus.rd_addr = w_rgb0;                end
      RD_G0: begin io_bus.rd_en = 1'b1; io_bus.rd_addr = w_rgb0 + ADDR_W'(1);   end
      RD_B0: begin io_bus.rd_en = 1'b1; io_bus.rd_addr = w_rgb0 + ADDR_W'(2);   end
      RD_R1: begin io_bus.rd_en = 1'b1; io_bus.rd_addr = w_rgb1;                end
      RD_G1: begin io_bus.rd_en = 1'b1; io_bus.rd_addr = w_rgb1 + ADDR_W'(1);   end
      RD_B1: begin io_bus.rd_en = 1'b1; io_bus.rd_addr = w_rgb1 + ADDR_W'(2);   end
      WR_Y0: begin
        io_bus.wr_en   = 1'b1;
        io_bus.wr_addr = Y_BASE + w_pix0;
        io_bus.wr_data = r_y0;
      end
      WR_Y1: begin
        io_bus.wr_en   = 1'b1;
        io_bus.wr_addr = Y_BASE + w_pix0 + ADDR_W'(1);
        io_bus.wr_data = r_y1;
      end
      WR_U: begin
        io_bus.wr_en   = 1'b1;
        io_bus.wr_addr = U_BASE + {1'b0, r_pair};
        io_bus.wr_data = r_u;
      end
      WR_V: begin
        io_bus.wr_en   = 1'b1;
        io_bus.wr_addr = V_BASE + {1'b0, r_pair};
        io_bus.wr_data = r_v;
      end
      DONE:    io_bus.done = 1'b1;
      default: ;
    endcase
  end

endmodule

`default_nettype wire
